// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
//   state_e : arbiter FSM encoding (IDLE, ISSUE, RESP)
//   owner_e : transaction owner (OWN_I = fetch, OWN_D = data)
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
package manta_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// Combinational owner choice for the memory port arbiter.
//   i_req, d_req : fetch / data request lines
//   starve_cnt   : saturated count of data grants made while fetch waited
//   grant        : at least one request is pending
//   owner        : winning requester (valid when grant=1)
// Data wins a tie unless fetch has been passed over STARVE_MAX times.
module arb_grant_sel
    import manta_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       i_req,
    input  logic       d_req,
    input  logic [3:0] starve_cnt,
    output logic       grant,
    output owner_e     owner
);

    always_comb begin
        grant = i_req | d_req;
        owner = OWN_D;
        if (i_req && !d_req) begin
            owner = OWN_I;
        end else if (i_req && d_req && (starve_cnt == 4'(STARVE_MAX))) begin
            owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch path and the data path,
// one outstanding transaction at a time.
//   clk, rst                       : clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata  : fetch request / response
//   d_req/d_we/d_addr/d_wdata
//                -> d_ack/d_rdata  : load/store request / response
//   m_req/m_we/m_addr/m_wdata      : memory request, held until m_ack
//   m_ack/m_rdata                  : memory completion pulse and read data
//   busy                           : FSM not in IDLE
//   err_timeout, err_spurious      : sticky error flags, cleared by rst
module mem_port_arbiter
    import manta_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 2);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [3:0]          starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_tmo_q, err_tmo_d;
    logic                err_spur_q, err_spur_d;

    logic                sel_grant;
    owner_e              sel_owner;

    arb_grant_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .grant      (sel_grant),
        .owner      (sel_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            starve_q   <= '0;
            tmo_q      <= '0;
            err_tmo_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            err_tmo_q  <= err_tmo_d;
            err_spur_q <= err_spur_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        err_tmo_d  = err_tmo_q;
        // Any completion outside ISSUE has no transaction to belong to.
        err_spur_d = err_spur_q | (m_ack && (state_q != ISSUE));

        case (state_q)
            IDLE: begin
                if (sel_grant) begin
                    state_d = ISSUE;
                    owner_d = sel_owner;
                    tmo_d   = '0;
                    if (sel_owner == OWN_I) begin
                        addr_d   = i_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        // Only count data grants that actually made fetch wait.
                        if (i_req && (starve_q != 4'(STARVE_MAX))) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    // Stores report zero read data to their owner.
                    rdata_d = we_q ? '0 : m_rdata;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                    err_tmo_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        m_req        = (state_q == ISSUE);
        m_we         = m_req & we_q;
        m_addr       = m_req ? addr_q  : '0;
        m_wdata      = m_req ? wdata_q : '0;
        i_ack        = (state_q == RESP) && (owner_q == OWN_I);
        d_ack        = (state_q == RESP) && (owner_q == OWN_D);
        i_rdata      = i_ack ? rdata_q : '0;
        d_rdata      = d_ack ? rdata_q : '0;
        err_timeout  = err_tmo_q;
        err_spurious = err_spur_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import manta_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_ack;
    logic [15:0] m_rdata;
    logic        busy;
    logic        err_timeout;
    logic        err_spurious;

    logic        g_i, g_d, g_grant;
    logic [3:0]  g_cnt;
    owner_e      g_owner;

    int unsigned tests;
    int unsigned failed;

    mem_port_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ack        (m_ack),
        .m_rdata      (m_rdata),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    arb_grant_sel #(
        .STARVE_MAX (4)
    ) u_sel (
        .i_req      (g_i),
        .d_req      (g_d),
        .starve_cnt (g_cnt),
        .grant      (g_grant),
        .owner      (g_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic sel_case(input logic i, input logic d, input logic [3:0] c,
                            input logic eg, input logic eo, input string tag);
        g_i = i; g_d = d; g_cnt = c;
        #1;
        chk({tag, "_grant"}, 80'(g_grant), 80'(eg));
        if (eg) chk({tag, "_owner"}, 80'(g_owner), 80'(eo));
    endtask

    // grant order for both requests held, STARVE_MAX=4: 1 = data, 0 = fetch
    logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
        g_i = 1'b0; g_d = 1'b0; g_cnt = '0;

        // grant selector truth table
        sel_case(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "sel_none");
        sel_case(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "sel_i_only");
        sel_case(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, "sel_d_only");
        sel_case(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, "sel_both_3");
        sel_case(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, "sel_both_max");

        // reset state
        cyc(); cyc();
        chk("reset_outs",
            80'({i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata,
                 busy, err_timeout, err_spurious}), 80'd0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", 80'(busy), 80'd0);

        // 1. lone fetch, ack 2 cycles after m_req
        i_req = 1'b1; i_addr = 16'h0010;
        cyc();
        chk("t1_mreq", 80'({m_req, m_we, m_addr}), 80'({1'b1, 1'b0, 16'h0010}));
        cyc();
        chk("t1_wait", 80'({m_req, i_ack}), 80'({1'b1, 1'b0}));
        cyc();
        m_ack = 1'b1; m_rdata = 16'hBEEF;
        cyc();
        m_ack = 1'b0; m_rdata = 16'h0000; i_req = 1'b0;
        chk("t1_iack", 80'({i_ack, i_rdata, d_ack, m_req}), 80'({1'b1, 16'hBEEF, 1'b0, 1'b0}));
        cyc();
        chk("t1_done", 80'({i_ack, d_ack, busy}), 80'd0);

        // 2. lone store
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        cyc();
        chk("t2_mreq", 80'({m_req, m_we, m_addr, m_wdata, busy}),
            80'({1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1}));
        m_ack = 1'b1; m_rdata = 16'hFFFF;
        cyc();
        m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("t2_dack", 80'({d_ack, d_rdata, i_ack, busy}), 80'({1'b1, 16'h0000, 1'b0, 1'b1}));
        cyc();
        chk("t2_done", 80'({d_ack, busy}), 80'd0);

        // 3. both requests held, memory acks in the 2nd ISSUE cycle
        i_req = 1'b1; i_addr = 16'h0111;
        d_req = 1'b1; d_addr = 16'h0222; d_we = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            chk($sformatf("t3_addr%0d", n), 80'({m_req, m_addr}),
                80'({1'b1, exp_d[n] ? 16'h0222 : 16'h0111}));
            cyc();
            m_ack = 1'b1; m_rdata = 16'(16'hA000 + n);
            cyc();
            m_ack = 1'b0;
            if (n == 9) begin i_req = 1'b0; d_req = 1'b0; end
            chk($sformatf("t3_ack%0d", n), 80'({i_ack, d_ack, i_rdata, d_rdata, m_req}),
                80'({!exp_d[n], exp_d[n],
                     exp_d[n] ? 16'h0000 : 16'(16'hA000 + n),
                     exp_d[n] ? 16'(16'hA000 + n) : 16'h0000, 1'b0}));
            cyc();
            chk($sformatf("t3_gap%0d", n), 80'({m_req, busy}), 80'd0);
        end

        // 6. requester holds req through its ack cycle
        i_req = 1'b1; i_addr = 16'h0333;
        cyc();
        chk("t6_mreq", 80'({m_req, m_addr}), 80'({1'b1, 16'h0333}));
        m_ack = 1'b1; m_rdata = 16'h5A5A;
        cyc();
        m_ack = 1'b0;
        chk("t6_iack", 80'({i_ack, i_rdata}), 80'({1'b1, 16'h5A5A}));
        cyc();
        chk("t6_no_regrant", 80'({m_req, busy, i_ack}), 80'd0);
        i_req = 1'b0;
        cyc();
        chk("t6_idle", 80'({m_req, busy}), 80'd0);

        // 4. timeout with TIMEOUT=8, memory silent
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0444; m_rdata = 16'hDEAD;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("t4_mreq%0d", k), 80'({m_req, d_ack, err_timeout}),
                80'({1'b1, 1'b0, 1'b0}));
        end
        cyc();
        d_req = 1'b0;
        chk("t4_dack", 80'({d_ack, d_rdata, m_req, err_timeout}),
            80'({1'b1, 16'h0000, 1'b0, 1'b1}));
        cyc();
        cyc();
        chk("t4_sticky", 80'({err_timeout, busy}), 80'({1'b1, 1'b0}));

        // 5. reset mid-ISSUE, late m_ack becomes spurious
        i_req = 1'b1; i_addr = 16'h0555;
        cyc();
        chk("t5_mreq", 80'({m_req, m_addr}), 80'({1'b1, 16'h0555}));
        rst = 1'b1; i_req = 1'b0;
        cyc();
        chk("t5_rst_outs",
            80'({i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata,
                 busy, err_timeout, err_spurious}), 80'd0);
        rst = 1'b0;
        cyc();
        chk("t5_no_ack1", 80'({i_ack, d_ack, busy}), 80'd0);
        cyc();
        m_ack = 1'b1; m_rdata = 16'h7777;
        cyc();
        m_ack = 1'b0;
        chk("t5_spur", 80'({err_spurious, i_ack, d_ack, busy}), 80'({1'b1, 1'b0, 1'b0, 1'b0}));
        cyc();
        chk("t5_spur_sticky", 80'({err_spurious, i_ack, d_ack}), 80'({1'b1, 1'b0, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
